// File: rtl/add_pkg.sv
// Shared types and constants for the adder-result frame accumulator.
package add_pkg;

   // Four guard bits cover up to 15 beats of {cout,S} without overflow.
   localparam int GUARD_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic [3:0] eff_len(input logic [3:0] len);
      return (len == 4'd0) ? 4'd1 : len;
   endfunction

endpackage

// File: rtl/acc_core.sv
// Frame accumulator datapath: running sum, beat counter and latched frame length.
module acc_core
   import add_pkg::*;
#(
   parameter int width = 21
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     load_i,
   input  logic                     add_i,
   input  logic [width:0]           value_i,
   input  logic [3:0]               len_i,
   output logic [width+GUARD_W:0]   acc_o,
   output logic [3:0]               cnt_o,
   output logic [3:0]               len_o
);

   localparam int OUT_W = width + 1 + GUARD_W;

   logic [OUT_W-1:0] acc_q, acc_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       len_q, len_d;
   logic [OUT_W-1:0] value_ext;

   assign value_ext = {{GUARD_W{1'b0}}, value_i};

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      len_d = len_q;
      if (clear_i) begin
         acc_d = '0;
         cnt_d = '0;
         len_d = '0;
      end else if (load_i) begin
         acc_d = value_ext;
         cnt_d = 4'd1;
         len_d = len_i;
      end else if (add_i) begin
         acc_d = acc_q + value_ext;
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   assign acc_o = acc_q;
   assign cnt_o = cnt_q;
   assign len_o = len_q;

endmodule

// File: rtl/add_result_acc.sv
// Sums 1..15 adder results {cout,S} per frame and hands the total downstream.
// Optional macro ACC_CLEAR_EN adds a clr input that aborts the current frame.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACCUM | collecting the remaining beats of the frame
// DONE  | total presented, waiting for out_ready
module add_result_acc
   import add_pkg::*;
#(
   parameter  int width = 21,
   localparam int OUT_W = width + 1 + GUARD_W
) (
   input  logic             clk,
   input  logic             rst,
`ifdef ACC_CLEAR_EN
   input  logic             clr,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_s,
   input  logic             in_cout,
   input  logic [3:0]       frame_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [3:0]       out_count
);

   state_t           state_q, state_d;
   logic             clr_w;
   logic             accept;
   logic             last_beat;
   logic             core_clear;
   logic [OUT_W-1:0] acc;
   logic [3:0]       cnt;
   logic [3:0]       len;

`ifdef ACC_CLEAR_EN
   assign clr_w = clr;
`else
   assign clr_w = 1'b0;
`endif

   // A beat arriving together with clr is dropped along with the frame.
   assign accept     = in_valid && in_ready && !clr_w;
   assign last_beat  = (cnt + 4'd1) == len;
   assign core_clear = clr_w || ((state_q == DONE) && out_ready);

   acc_core #(.width(width)) u_core (
      .clk     (clk),
      .rst     (rst),
      .clear_i (core_clear),
      .load_i  (accept && (state_q == IDLE)),
      .add_i   (accept && (state_q == ACCUM)),
      .value_i ({in_cout, in_s}),
      .len_i   (eff_len(frame_len)),
      .acc_o   (acc),
      .cnt_o   (cnt),
      .len_o   (len)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr_w) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = (eff_len(frame_len) == 4'd1) ? DONE : ACCUM;
            ACCUM:   if (accept && last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      out_data  = '0;
      out_count = '0;
      if (state_q == DONE) begin
         in_ready  = 1'b0;
         out_valid = 1'b1;
         out_data  = acc;
         out_count = len;
      end
   end

endmodule
